// File: rtl/activation_writeback.sv
// Requantizes signed neuron results (ReLU, shift, clamp) into an activation buffer.
// Build option: define ACT_ROUNDING_EN for round-half-up before the shift.
module activation_writeback #(
  parameter int unsigned OUTPUT_SIZE   = 512,
  parameter int unsigned BIAS_WIDTH    = 32,
  parameter int unsigned WEIGHTS_WIDTH = 8,
  parameter int unsigned SHIFT         = 7,
  localparam int unsigned AW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [BIAS_WIDTH-1:0]    in_data,
  output logic                     in_ready,
  input  logic [AW-1:0]            rd_addr,
  output logic [WEIGHTS_WIDTH-1:0] rd_data,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              sat_count
);

  typedef enum logic [1:0] {StIdle, StCollect, StDrain, StDone} state_e;

  localparam logic [BIAS_WIDTH:0] MaxAct =
    {{(BIAS_WIDTH + 1 - WEIGHTS_WIDTH){1'b0}}, {WEIGHTS_WIDTH{1'b1}}};
  localparam logic [AW-1:0] LastIdx = AW'(OUTPUT_SIZE - 1);

  state_e                   state_q;
  logic [AW-1:0]            idx_q;

  logic                     s1_valid_q;
  logic [BIAS_WIDTH:0]      s1_data_q;
  logic [AW-1:0]            s1_addr_q;
  logic                     s2_valid_q;
  logic [WEIGHTS_WIDTH-1:0] s2_data_q;
  logic [AW-1:0]            s2_addr_q;

  logic [WEIGHTS_WIDTH-1:0] mem [OUTPUT_SIZE];

  logic                     accept;
  logic                     start_ok;
  logic [BIAS_WIDTH:0]      relu;
  logic [BIAS_WIDTH:0]      s1_next;
  logic                     clamp;
  logic [WEIGHTS_WIDTH-1:0] s2_next;
  logic [31:0]              rd_addr_ext;

  assign accept      = in_valid && in_ready;
  assign start_ok    = start && ((state_q == StIdle) || (state_q == StDone));
  assign rd_addr_ext = 32'(rd_addr);

  always_comb begin
    relu = in_data[BIAS_WIDTH-1] ? '0 : {1'b0, in_data};
`ifdef ACT_ROUNDING_EN
    // Sum is one bit wider than the input, so adding the half-LSB cannot overflow.
    s1_next = (SHIFT > 0) ? ((relu + ((BIAS_WIDTH + 1)'(1) << (SHIFT - 1))) >> SHIFT) : relu;
`else
    s1_next = relu >> SHIFT;
`endif
  end

  always_comb begin
    clamp   = s1_data_q > MaxAct;
    s2_next = clamp ? {WEIGHTS_WIDTH{1'b1}} : s1_data_q[WEIGHTS_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      idx_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q  <= StCollect;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            idx_q    <= '0;
          end
        end
        StCollect: begin
          if (accept) begin
            idx_q <= idx_q + 1'b1;
            if (idx_q == LastIdx) begin
              state_q  <= StDrain;
              in_ready <= 1'b0;
            end
          end
        end
        StDrain: begin
          // Pipeline empty means the final write landed on the previous edge.
          if (!s1_valid_q && !s2_valid_q) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      sat_count  <= '0;
    end else begin
      s1_valid_q <= accept;
      s1_data_q  <= s1_next;
      s1_addr_q  <= idx_q;
      s2_valid_q <= s1_valid_q;
      s2_data_q  <= s2_next;
      s2_addr_q  <= s1_addr_q;
      if (start_ok) begin
        sat_count <= '0;
      end else if (s1_valid_q && clamp && (sat_count != 16'hffff)) begin
        sat_count <= sat_count + 16'd1;
      end
    end
  end

  // Reset also blocks the write that would otherwise land on the reset edge.
  always_ff @(posedge clk) begin
    if (s2_valid_q && !rst) begin
      mem[s2_addr_q] <= s2_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_addr_ext < OUTPUT_SIZE) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_activation_writeback.sv
// Directed bench for activation_writeback with a readback scoreboard.
module tb_activation_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [1:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        busy;
  logic        done;
  logic [15:0] sat_count;

  int          vectors = 0;
  int          miscompares = 0;
  int          exp_sat = 0;
  int          n;
  logic [7:0]  q[$];

  activation_writeback #(
    .OUTPUT_SIZE  (4),
    .BIAS_WIDTH   (32),
    .WEIGHTS_WIDTH(8),
    .SHIFT        (7)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done),
    .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference requantizer: ReLU, optional half-LSB round, shift by 7, clamp to 255.
  function automatic logic [7:0] quant(input int v, output bit sat);
    longint t;
    t = (v < 0) ? 0 : longint'(v);
`ifdef ACT_ROUNDING_EN
    t = t + 64;
`endif
    t = t >>> 7;
    sat = (t > 255);
    return sat ? 8'd255 : t[7:0];
  endfunction

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_sat = 0;
  endtask

  task automatic send(input int v);
    bit s;
    check("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    in_data  = v;
    q.push_back(quant(v, s));
    if (s) exp_sat++;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < 20) begin
      tick();
      cycles++;
    end
    check("done_within_bound", done, 1);
  endtask

  task automatic readback();
    logic [7:0] e;
    for (int a = 0; a < 4; a++) begin
      rd_addr = a[1:0];
      tick();
      if (q.size() == 0) begin
        check("scoreboard_empty", 1, 0);
      end else begin
        e = q.pop_front();
        check($sformatf("buf[%0d]", a), rd_data, e);
      end
    end
  endtask

  initial begin
    bit         s;
    logic [7:0] prior1;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; rd_addr = '0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_sat_count", sat_count, 0);
    check("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    tick();
    check("idle_in_ready", in_ready, 0);

    // Back-to-back stream with DONE latency check.
    do_start();
    check("collect_busy", busy, 1);
    check("collect_done", done, 0);
    send(256); send(-5); send(40000); send(127);
    check("drain_in_ready", in_ready, 0);
    check("drain_busy", busy, 1);
    wait_done(n);
    check("done_latency", n, 3);
    check("done_busy", busy, 0);
    check("sat_count_pass1", sat_count, exp_sat);
    readback();

    // Gapped stream: IN_READY holds until the last accept.
    do_start();
    check("restart_done_clear", done, 0);
    check("restart_sat_clear", sat_count, 0);
    send(1000);
    for (int g = 0; g < 3; g++) begin tick(); check("gap_in_ready", in_ready, 1); end
    send(-1);
    for (int g = 0; g < 3; g++) begin tick(); check("gap_in_ready", in_ready, 1); end
    send(512);
    for (int g = 0; g < 3; g++) begin tick(); check("gap_in_ready", in_ready, 1); end
    send(33000);
    check("gap_last_in_ready", in_ready, 0);
    wait_done(n);
    check("sat_count_gapped", sat_count, exp_sat);
    readback();

    // START mid-pass ignored; a fifth value after four accepts is refused.
    do_start();
    send(300);
    start = 1'b1;
    send(600);
    start = 1'b0;
    check("start_ignored_busy", busy, 1);
    send(900); send(1200);
    in_valid = 1'b1;
    in_data  = 5000;
    check("fifth_in_ready", in_ready, 0);
    tick();
    in_valid = 1'b0;
    wait_done(n);
    check("sat_count_none", sat_count, exp_sat);
    readback();

    // Read-during-write on address 2 returns old data, then new.
    rd_addr = 2'd2;
    do_start();
    send(128); send(256); send(1280); send(384);
    tick();
    check("rdw_old", rd_data, quant(900, s));
    tick();
    check("rdw_new", rd_data, quant(1280, s));
    wait_done(n);
    readback();

    // Reset mid-pass: nothing further written, address 1 keeps its prior value.
    prior1 = quant(256, s);
    do_start();
    send(5000); send(6400);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_done", done, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    for (int g = 0; g < 4; g++) tick();
    rd_addr = 2'd1;
    tick();
    check("midrst_addr1_kept", rd_data, prior1);
    rd_addr = 2'd2;
    tick();
    check("midrst_addr2_kept", rd_data, quant(1280, s));

    // Reset wins over START and IN_VALID.
    rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 256;
    tick();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    check("rst_prio_busy", busy, 0);
    check("rst_prio_in_ready", in_ready, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
